sync_deglitch: RTL and testbench

Single-bit debounce/deglitch stage that sits directly downstream of the multi-flop clock-domain synchronizer, in the destination clock domain. It accepts the already-synchronized level, requires it to be stable for a programmable number of cycles before accepting a change, and publishes a clean level plus one-cycle rise/fall event pulses. An optional saturating counter records rejected glitches for status readback.

---
 rtl/sync_deglitch_pkg.sv | 30 +++
 rtl/sync_deglitch_sat_counter.sv | 31 +++
 rtl/sync_deglitch.sv | 169 ++++++++++++++++
 tb/tb_sync_deglitch.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_deglitch_pkg.sv
// -----------------------------------------------------------------------------
// sync_deglitch_pkg
// Shared definitions for the sync_deglitch block:
//   - state_t     : deglitch FSM state encoding
//   - FILTER_LEN_MIN / FILTER_LEN_MAX : legal FILTER_LEN range
//   - clog2()     : ceiling log2, used to size the run counter
// -----------------------------------------------------------------------------
package sync_deglitch_pkg;

    // bit 1 is the published level, bit 0 marks a pending change
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

    localparam int unsigned FILTER_LEN_MIN = 1;
    localparam int unsigned FILTER_LEN_MAX = 65535;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage : sync_deglitch_pkg

// File: rtl/sync_deglitch_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that increments on inc and holds once it reaches all-ones.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (count cleared to 0)
//   inc    in   increment request, one count per cycle asserted
//   count  out  W-bit saturating count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    if (W < 1) begin : g_bad_w
        $error("sat_counter: W must be at least 1");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/sync_deglitch.sv
// -----------------------------------------------------------------------------
// sync_deglitch
// Debounce/deglitch stage for a single already-synchronized level. A change
// on d is accepted only after FILTER_LEN consecutive differing samples; q is
// the filtered level, rise/fall are one-cycle pulses on accepted edges.
// All outputs are registered.
//
// Build option: define SYNC_DEGLITCH_GLITCH_CNT_EN to add the glitch_cnt
// port, a saturating count of changes that reverted before being accepted.
//
// Ports:
//   clk         in   destination-domain clock
//   rst_n       in   asynchronous active-low reset
//   d           in   synchronized input level
//   q           out  filtered level (reset INIT)
//   rise        out  one-cycle pulse when q goes 0->1
//   fall        out  one-cycle pulse when q goes 1->0
//   glitch_cnt  out  CNT_W-bit saturating glitch count (macro only)
//
// state     | meaning
// ----------+------------------------------------------------------------
// STABLE_LO | q=0, d agrees, run counter idle at 0
// CHK_HI    | q=0, d has been high for run consecutive samples
// STABLE_HI | q=1, d agrees, run counter idle at 0
// CHK_LO    | q=1, d has been low for run consecutive samples
// -----------------------------------------------------------------------------
module sync_deglitch
    import sync_deglitch_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4,
    parameter logic        INIT       = 1'b0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    output logic             q,
    output logic             rise,
    output logic             fall
`ifdef SYNC_DEGLITCH_GLITCH_CNT_EN
    ,
    output logic [CNT_W-1:0] glitch_cnt
`endif
);

    if ((FILTER_LEN < FILTER_LEN_MIN) || (FILTER_LEN > FILTER_LEN_MAX)) begin : g_bad_len
        $error("sync_deglitch: FILTER_LEN out of range 1..65535");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("sync_deglitch: CNT_W must be at least 1");
    end

    localparam int unsigned     RUN_W     = clog2(FILTER_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);
    localparam state_t          RST_STATE = INIT ? STABLE_HI : STABLE_LO;

    state_t           state;
    state_t           state_nxt;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_nxt;
    logic             q_nxt;
    logic             rise_nxt;
    logic             fall_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
            run   <= '0;
            q     <= INIT;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
            q     <= q_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        q_nxt     = q;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;

        case (state)
            STABLE_LO: begin
                run_nxt = '0;
                if (d) begin
                    if (FILTER_LEN == 1) begin
                        state_nxt = STABLE_HI;
                        q_nxt     = 1'b1;
                        rise_nxt  = 1'b1;
                    end else begin
                        state_nxt = CHK_HI;
                        run_nxt   = RUN_W'(1);
                    end
                end
            end

            CHK_HI: begin
                if (!d) begin
                    state_nxt = STABLE_LO;
                    run_nxt   = '0;
                end else if (run == RUN_LAST) begin
                    state_nxt = STABLE_HI;
                    q_nxt     = 1'b1;
                    rise_nxt  = 1'b1;
                    run_nxt   = '0;
                end else begin
                    run_nxt = run + RUN_W'(1);
                end
            end

            STABLE_HI: begin
                run_nxt = '0;
                if (!d) begin
                    if (FILTER_LEN == 1) begin
                        state_nxt = STABLE_LO;
                        q_nxt     = 1'b0;
                        fall_nxt  = 1'b1;
                    end else begin
                        state_nxt = CHK_LO;
                        run_nxt   = RUN_W'(1);
                    end
                end
            end

            CHK_LO: begin
                if (d) begin
                    state_nxt = STABLE_HI;
                    run_nxt   = '0;
                end else if (run == RUN_LAST) begin
                    state_nxt = STABLE_LO;
                    q_nxt     = 1'b0;
                    fall_nxt  = 1'b1;
                    run_nxt   = '0;
                end else begin
                    run_nxt = run + RUN_W'(1);
                end
            end

            default: begin
                state_nxt = RST_STATE;
                run_nxt   = '0;
                q_nxt     = INIT;
            end
        endcase
    end

`ifdef SYNC_DEGLITCH_GLITCH_CNT_EN
    // A pending change that reverts is the only way a CHK state exits
    // back to its own STABLE level, so this is exactly one event per glitch.
    logic glitch;
    assign glitch = ((state == CHK_HI) && !d) || ((state == CHK_LO) && d);

    sat_counter #(
        .W (CNT_W)
    ) u_glitch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (glitch),
        .count (glitch_cnt)
    );
`endif

endmodule : sync_deglitch

// File: tb/tb_sync_deglitch.sv
module tb_sync_deglitch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] dv = 4'b0000;

    logic q_a, rise_a, fall_a;
    logic q_b, rise_b, fall_b;
    logic q_c, rise_c, fall_c;
    logic q_d, rise_d, fall_d;
`ifdef SYNC_DEGLITCH_GLITCH_CNT_EN
    logic [15:0] gc_a, gc_b, gc_c;
    logic [1:0]  gc_d;
`endif

    int checks = 0;
    int failures = 0;

    // per-instance configuration: a, b, c, d
    int len_cfg[4]  = '{4, 4, 1, 8};
    int init_cfg[4] = '{0, 1, 0, 0};
    int cmax_cfg[4] = '{65535, 65535, 65535, 3};

    // reference model: published level, length of current differing run,
    // pulses produced on the last edge, saturating glitch count
    int m_q[4];
    int m_run[4];
    int m_rise[4];
    int m_fall[4];
    int m_gc[4];

    always #5 clk = ~clk;

    sync_deglitch #(.FILTER_LEN(4), .INIT(1'b0), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .d(dv[0]), .q(q_a), .rise(rise_a), .fall(fall_a)
`ifdef SYNC_DEGLITCH_GLITCH_CNT_EN
        , .glitch_cnt(gc_a)
`endif
    );
    sync_deglitch #(.FILTER_LEN(4), .INIT(1'b1), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .d(dv[1]), .q(q_b), .rise(rise_b), .fall(fall_b)
`ifdef SYNC_DEGLITCH_GLITCH_CNT_EN
        , .glitch_cnt(gc_b)
`endif
    );
    sync_deglitch #(.FILTER_LEN(1), .INIT(1'b0), .CNT_W(16)) u_c (
        .clk(clk), .rst_n(rst_n), .d(dv[2]), .q(q_c), .rise(rise_c), .fall(fall_c)
`ifdef SYNC_DEGLITCH_GLITCH_CNT_EN
        , .glitch_cnt(gc_c)
`endif
    );
    sync_deglitch #(.FILTER_LEN(8), .INIT(1'b0), .CNT_W(2)) u_d (
        .clk(clk), .rst_n(rst_n), .d(dv[3]), .q(q_d), .rise(rise_d), .fall(fall_d)
`ifdef SYNC_DEGLITCH_GLITCH_CNT_EN
        , .glitch_cnt(gc_d)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_q[i]    = init_cfg[i];
            m_run[i]  = 0;
            m_rise[i] = 0;
            m_fall[i] = 0;
            m_gc[i]   = 0;
        end
    endtask

    task automatic check_all(input string where);
        logic [3:0]  oq, orise, ofall;
        logic [31:0] ogc[4];
        oq    = {q_d, q_c, q_b, q_a};
        orise = {rise_d, rise_c, rise_b, rise_a};
        ofall = {fall_d, fall_c, fall_b, fall_a};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s q[%0d]", where, i), 32'(oq[i]), 32'(m_q[i]));
            chk($sformatf("%s rise[%0d]", where, i), 32'(orise[i]), 32'(m_rise[i]));
            chk($sformatf("%s fall[%0d]", where, i), 32'(ofall[i]), 32'(m_fall[i]));
        end
`ifdef SYNC_DEGLITCH_GLITCH_CNT_EN
        ogc[0] = 32'(gc_a);
        ogc[1] = 32'(gc_b);
        ogc[2] = 32'(gc_c);
        ogc[3] = 32'(gc_d);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s glitch_cnt[%0d]", where, i), ogc[i], 32'(m_gc[i]));
        end
`else
        ogc[0] = 32'd0;
`endif
    endtask

    // drive new levels, let one edge sample them, update the model, check
    task automatic step(input logic [3:0] nd, input string where);
        dv = nd;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            m_rise[i] = 0;
            m_fall[i] = 0;
            if (int'(nd[i]) != m_q[i]) begin
                m_run[i]++;
                if (m_run[i] == len_cfg[i]) begin
                    m_q[i]    = int'(nd[i]);
                    m_rise[i] = int'(nd[i]);
                    m_fall[i] = 1 - int'(nd[i]);
                    m_run[i]  = 0;
                end
            end else begin
                if (m_run[i] > 0 && m_gc[i] < cmax_cfg[i]) m_gc[i]++;
                m_run[i] = 0;
            end
        end
        #1;
        check_all(where);
    endtask

    initial begin
        logic [3:0] nd;
        int         tog;

        // power-on reset, b sees d=1 with INIT=1
        dv = 4'b0010;
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all("rst_async");
        repeat (2) begin
            @(posedge clk);
            #1 check_all("rst_held");
        end
        #3 rst_n = 1'b1;

        // a: 0->1 held; rise after the 4th sampling edge with d high
        for (int k = 0; k < 6; k++) begin
            step(4'b0011, "dir_rise");
            if (k == 2) chk("dir_rise_pending_q_a", 32'(q_a), 32'd0);
            if (k == 3) chk("dir_rise_pulse_a", 32'(rise_a), 32'd1);
            if (k == 4) chk("dir_rise_single_a", 32'(rise_a), 32'd0);
        end
        chk("dir_rise_no_fall_a", 32'(fall_a), 32'd0);

        // return a to low
        for (int k = 0; k < 5; k++) step(4'b0010, "dir_fall");
        chk("dir_fall_q_a", 32'(q_a), 32'd0);

        // glitches: 3 high then 1 low on a and d; c toggles every cycle
        tog = 0;
        for (int g = 0; g < 6; g++) begin
            for (int k = 0; k < 4; k++) begin
                nd = (k < 3) ? 4'b1011 : 4'b0010;
                if (g == 5) nd[0] = 1'b0;
                nd[2] = tog[0];
                tog++;
                step(nd, "glitch");
            end
`ifdef SYNC_DEGLITCH_GLITCH_CNT_EN
            if (g == 4) chk("glitch_cnt_a_five", 32'(gc_a), 32'd5);
`endif
        end
        chk("glitch_q_a_low", 32'(q_a), 32'd0);
        chk("glitch_q_d_low", 32'(q_d), 32'd0);
`ifdef SYNC_DEGLITCH_GLITCH_CNT_EN
        chk("glitch_cnt_d_sat", 32'(gc_d), 32'd3);
        chk("glitch_cnt_c_zero", 32'(gc_c), 32'd0);
`endif

        // random runs: per-cycle flip probability 1/4 (a,b,c) and 1/10 (d)
        nd = dv;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 3) == 0) nd[i] = ~nd[i];
            end
            if ($urandom_range(0, 9) == 0) nd[3] = ~nd[3];
            step(nd, "random");
        end

        // settle low, then hold high 5 cycles and reset mid-check on d
        for (int k = 0; k < 10; k++) step(4'b0000, "settle");
        for (int k = 0; k < 5; k++) step(4'b1111, "pre_rst");
        chk("pre_rst_q_d_low", 32'(q_d), 32'd0);
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_all("mid_chk_rst");
        chk("mid_chk_rst_q_d", 32'(q_d), 32'd0);
        @(posedge clk);
        #1 check_all("mid_chk_rst_held");
        #3 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step(4'b0010, "post_rst");
        chk("post_rst_no_rise_d", 32'(rise_d), 32'd0);
`ifdef SYNC_DEGLITCH_GLITCH_CNT_EN
        chk("post_rst_gc_d", 32'(gc_d), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sync_deglitch
